// File: rtl/key_debounce.sv
// Per-channel button conditioner: 2-flop synchronizer, polarity normalisation and
// a stable-count filter producing a debounced active-high level plus a change strobe.
//
// state  | meaning
// STABLE | normalised sample equals btn; counter held at zero
// CHECK  | sample differs from btn; counter runs until STABLE_CYCLES agreeing samples
module key_debounce #(
    parameter int WIDTH          = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] changed
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic INACTIVE_RAW = (KEY_ACTIVE_LOW != 0);

    if (STABLE_CYCLES < 2) begin : g_param_check
        $error("key_debounce: STABLE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] btn_q, btn_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] norm;

    // The STABLE/CHECK state is implied by norm vs btn, so no separate state register.
    assign norm = sync2_q ^ {WIDTH{INACTIVE_RAW}};

    always_comb begin
        btn_d = btn_q;
        chg_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (norm[i] != btn_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    btn_d[i] = ~btn_q[i];
                    chg_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= {WIDTH{INACTIVE_RAW}};
            sync2_q <= {WIDTH{INACTIVE_RAW}};
            btn_q   <= '0;
            chg_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            btn_q   <= btn_d;
            chg_q   <= chg_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn     = btn_q;
    assign changed = chg_q;

endmodule
